tpu_sequencer: RTL

//  Programmable instruction sequencer for the TPU. It replaces the hard-coded fetch/execute loop in the top level.

---
 rtl/tpu_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/tpu_sequencer.sv
// Programmable TPU instruction sequencer: host-loaded instruction memory, start/busy/done handshake.
// Optional build macro TPU_SEQ_WAIT_EN turns opcode 110 into WAIT n (otherwise it is a NOP).
//
// state  | meaning
// IDLE   | waiting for start; instruction memory writable
// FETCH  | latch imem[pc] into instr_q
// EXEC   | decode instr_q and drive its strobe
// HOLD   | extra COMPUTE cycles (valid high) or WAIT cycles (all strobes low)
// FINISH | one-cycle done pulse, then back to IDLE
module tpu_sequencer #(
  parameter int INSTR_W        = 16,
  parameter int IMEM_DEPTH     = 8,
  parameter int ADDR_W         = INSTR_W - 3,
  parameter int COMPUTE_CYCLES = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [INSTR_W-1:0]            prog_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic [ADDR_W-1:0]             base_address,
  output logic                          load_weight,
  output logic                          load_input,
  output logic                          valid,
  output logic                          store
);
  localparam int PC_W      = $clog2(IMEM_DEPTH);
  localparam int CNT_W     = (COMPUTE_CYCLES > 256) ? $clog2(COMPUTE_CYCLES) : 8;
  localparam int HOLD_INIT = (COMPUTE_CYCLES > 1) ? COMPUTE_CYCLES - 2 : 0;

  localparam logic [2:0] OP_HALT    = 3'b000;
  localparam logic [2:0] OP_LDADDR  = 3'b001;
  localparam logic [2:0] OP_LDW     = 3'b010;
  localparam logic [2:0] OP_LDIN    = 3'b011;
  localparam logic [2:0] OP_COMPUTE = 3'b100;
  localparam logic [2:0] OP_STORE   = 3'b101;
`ifdef TPU_SEQ_WAIT_EN
  localparam logic [2:0] OP_WAIT    = 3'b110;
`endif

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HOLD, S_FINISH} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]    hold_q, hold_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [INSTR_W-1:0]  imem [IMEM_DEPTH];
  logic [2:0]          opcode;
  logic                at_end;
  logic                advance;

  assign opcode = instr_q[INSTR_W-1 -: 3];
  assign at_end = (pc_q == PC_W'(IMEM_DEPTH - 1));

  // Memory has no reset so a program survives an aborted run.
  always_ff @(posedge clk) begin
    if (prog_we && state_q == S_IDLE) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      hold_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      hold_q  <= hold_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    hold_d  = hold_q;
    base_d  = base_q;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        instr_d = imem[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_HALT:   state_d = S_FINISH;
          OP_LDADDR: begin
            base_d  = ADDR_W'(instr_q[INSTR_W-4:0]);
            advance = 1'b1;
          end
          OP_COMPUTE: begin
            if (COMPUTE_CYCLES > 1) begin
              hold_d  = CNT_W'(HOLD_INIT);
              state_d = S_HOLD;
            end else begin
              advance = 1'b1;
            end
          end
`ifdef TPU_SEQ_WAIT_EN
          OP_WAIT: begin
            if (instr_q[7:0] != 8'd0) begin
              hold_d  = CNT_W'(instr_q[7:0] - 8'd1);
              state_d = S_HOLD;
            end else begin
              advance = 1'b1;
            end
          end
`endif
          default:   advance = 1'b1;
        endcase
      end
      S_HOLD: begin
        if (hold_q == '0) advance = 1'b1;
        else              hold_d  = hold_q - 1'b1;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // The last memory word ends the run instead of wrapping pc.
    if (advance) begin
      if (at_end) begin
        state_d = S_FINISH;
      end else begin
        pc_d    = pc_q + 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_FINISH);
    pc           = pc_q;
    base_address = base_q;
    load_weight  = (state_q == S_EXEC) && (opcode == OP_LDW);
    load_input   = (state_q == S_EXEC) && (opcode == OP_LDIN);
    store        = (state_q == S_EXEC) && (opcode == OP_STORE);
    valid        = ((state_q == S_EXEC) || (state_q == S_HOLD)) && (opcode == OP_COMPUTE);
  end

endmodule
